// File: rtl/highscore_table_if.sv
// Game-side bus for the score keeper: live-score controls, display selector and
// the BCD result with its status flags.
interface highscore_table_if #(
    parameter int SEL_W  = 3,
    parameter int DIGITS = 4
);
    logic                  increment;
    logic                  is_dead;
    logic [SEL_W-1:0]      sel;
    logic [4*DIGITS-1:0]   digits;
    logic [3:0]            sel_echo;
    logic                  busy;
    logic                  new_record;

    modport master (
        output increment, is_dead, sel,
        input  digits, sel_echo, busy, new_record
    );

    modport slave (
        input  increment, is_dead, sel,
        output digits, sel_echo, busy, new_record
    );
endinterface

// File: rtl/highscore_table.sv
// Live score counter, descending top-DEPTH table and a bit-serial double-dabble
// converter that drives stable BCD digits for one selected entry.
module highscore_table #(
    parameter int SCORE_W = 11,
    parameter int DEPTH   = 4,
    parameter int DIGITS  = 4,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    highscore_table_if.slave  bus
);
    localparam logic [SCORE_W-1:0] MAX_SCORE = '1;
    localparam int                 CNT_W     = $clog2(SCORE_W + 1);
    localparam int                 BCD_W     = 4 * DIGITS;
    localparam int                 DD_W      = BCD_W + SCORE_W;
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(SCORE_W - 1);
    localparam logic [0:0]         IDLE      = 1'b0;
    localparam logic [0:0]         SHIFT     = 1'b1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("highscore_table: DEPTH must be >= 1");
        end
        if (pow10(DIGITS) <= ((64'd1 << SCORE_W) - 64'd1)) begin : g_bad_digits
            $error("highscore_table: DIGITS too small for SCORE_W");
        end
    endgenerate

    // ---------------- live score and table ----------------
    logic [SCORE_W-1:0]            curr_score;
    logic [SCORE_W-1:0]            commit_val;
    logic                          do_commit;
    logic [DEPTH-1:0][SCORE_W-1:0] entry;
    logic [DEPTH-1:0][SCORE_W-1:0] shift_in;
    logic [DEPTH-1:0]              gt;
    logic                          new_record;

    assign commit_val = (bus.increment && curr_score != MAX_SCORE) ? curr_score + 1'b1 : curr_score;
    assign do_commit  = bus.is_dead && (commit_val != '0);

    // Table is descending, so gt is a thermometer: the first set bit is the
    // insert slot, every later set slot takes its upper neighbour.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            assign gt[i] = commit_val > entry[i];
            if (i == 0) begin : g_head
                assign shift_in[i] = commit_val;
            end else begin : g_tail
                assign shift_in[i] = gt[i-1] ? entry[i-1] : commit_val;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curr_score <= '0;
            entry      <= '0;
            new_record <= 1'b0;
        end else begin
            curr_score <= bus.is_dead ? '0 : commit_val;
            new_record <= do_commit && gt[0];
            for (int i = 0; i < DEPTH; i++)
                if (do_commit && gt[i]) entry[i] <= shift_in[i];
        end
    end

    // ---------------- selection ----------------
    logic [SCORE_W-1:0] v;

    always_comb begin
        v = '0;
        if (bus.sel == '0) v = curr_score;
        for (int k = 0; k < DEPTH; k++)
            if (bus.sel == SEL_W'(k + 1)) v = entry[k];
    end

    generate
        if (SEL_W >= 4) begin : g_echo_trunc
            assign bus.sel_echo = bus.sel[3:0];
        end else begin : g_echo_pad
            assign bus.sel_echo = {{(4-SEL_W){1'b0}}, bus.sel};
        end
    endgenerate

    // ---------------- double-dabble converter ----------------
    // BCD accumulator and binary source share one shift register {bcd, bin}.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++)
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        return r;
    endfunction

    logic [0:0]         state;
    logic [DD_W-1:0]    dd;
    logic [DD_W-1:0]    dd_next;
    logic [CNT_W-1:0]   cnt;
    logic [SCORE_W-1:0] last_conv;
    logic [BCD_W-1:0]   digits;
    logic               busy;

    assign dd_next = {add3(dd[DD_W-1 -: BCD_W]), dd[SCORE_W-1:0]} << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dd        <= '0;
            cnt       <= '0;
            last_conv <= '0;
            digits    <= '0;
            busy      <= 1'b0;
        end else if (state == IDLE) begin
            if (v != last_conv) begin
                dd        <= {{BCD_W{1'b0}}, v};
                last_conv <= v;
                cnt       <= '0;
                state     <= SHIFT;
                busy      <= 1'b1;
            end
        end else begin
            dd  <= dd_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
                digits <= dd_next[DD_W-1 -: BCD_W];
                state  <= IDLE;
                busy   <= 1'b0;
            end
        end
    end

    assign bus.digits     = digits;
    assign bus.busy       = busy;
    assign bus.new_record = new_record;
endmodule

// File: tb/tb_highscore_table.sv
// Directed bench for highscore_table: counting, table insertion, saturation,
// conversion latency/restart and asynchronous reset behaviour.
module tb_highscore_table;
    localparam int SCORE_W = 11;
    localparam int DEPTH   = 4;
    localparam int DIGITS  = 4;
    localparam int SEL_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    highscore_table_if #(.SEL_W(SEL_W), .DIGITS(DIGITS)) bus();

    highscore_table #(
        .SCORE_W(SCORE_W), .DEPTH(DEPTH), .DIGITS(DIGITS), .SEL_W(SEL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait until the converter has been quiet for two consecutive cycles.
    task automatic settle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 2; i++) begin
            tick();
            if (!bus.busy) quiet++;
            else quiet = 0;
        end
        check("settle", 32'(quiet >= 2), 32'd1);
    endtask

    task automatic show(input string tag, input logic [SEL_W-1:0] s, input logic [15:0] exp);
        bus.sel = s;
        settle();
        check(tag, 32'(bus.digits), 32'(exp));
    endtask

    task automatic play(input string tag, input int n, input logic exp_rec);
        for (int i = 0; i < n; i++) begin
            bus.increment = 1'b1;
            tick();
        end
        bus.increment = 1'b0;
        bus.is_dead   = 1'b1;
        tick();
        bus.is_dead = 1'b0;
        check(tag, 32'(bus.new_record), 32'(exp_rec));
        tick();
        check("rec_pulse_end", 32'(bus.new_record), 32'd0);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_digits", 32'(bus.digits), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        bus.increment = 1'b0;
        bus.is_dead   = 1'b0;
        bus.sel       = 3'd1;

        // Reset state
        repeat (3) tick();
        check("reset_digits", 32'(bus.digits), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_new_record", 32'(bus.new_record), 32'd0);
        check("sel_echo_1", 32'(bus.sel_echo), 32'd1);
        rst = 1'b1;

        // 37 increments while showing empty rank 1, then switch to live score
        for (int i = 0; i < 37; i++) begin
            bus.increment = 1'b1;
            tick();
        end
        bus.increment = 1'b0;
        check("idle_before_sel", 32'(bus.busy), 32'd0);
        bus.sel  = 3'd0;
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 11) busy_cnt += int'(bus.busy);
            if (k == 11) check("digits_hold", 32'(bus.digits), 32'd0);
        end
        check("latency_digits", 32'(bus.digits), 32'h0037);
        check("latency_busy_low", 32'(bus.busy), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'd11);

        // Table insertion and ties
        reset_pulse();
        bus.sel = 3'd5;
        play("rec_50", 50, 1'b1);
        play("rec_20a", 20, 1'b0);
        play("rec_80", 80, 1'b1);
        play("rec_20b", 20, 1'b0);
        show("sel5_zero", 3'd5, 16'h0000);
        check("sel_echo_5", 32'(bus.sel_echo), 32'd5);
        show("t1_r1", 3'd1, 16'h0080);
        show("t1_r2", 3'd2, 16'h0050);
        show("t1_r3", 3'd3, 16'h0020);
        show("t1_r4", 3'd4, 16'h0020);
        play("rec_10", 10, 1'b0);
        show("t2_r2", 3'd2, 16'h0050);
        show("t2_r4", 3'd4, 16'h0020);
        play("rec_60", 60, 1'b0);
        show("t3_r1", 3'd1, 16'h0080);
        show("t3_r2", 3'd2, 16'h0060);
        show("t3_r3", 3'd3, 16'h0050);
        show("t3_r4", 3'd4, 16'h0020);

        // increment and is_dead in the same cycle at score 9
        reset_pulse();
        bus.sel = 3'd5;
        for (int i = 0; i < 9; i++) begin
            bus.increment = 1'b1;
            tick();
        end
        bus.increment = 1'b1;
        bus.is_dead   = 1'b1;
        tick();
        bus.increment = 1'b0;
        bus.is_dead   = 1'b0;
        check("rec_both", 32'(bus.new_record), 32'd1);
        show("both_live_zero", 3'd0, 16'h0000);
        show("both_r1", 3'd1, 16'h0010);

        // Saturation
        bus.sel = 3'd5;
        for (int i = 0; i < 2100; i++) begin
            bus.increment = 1'b1;
            tick();
        end
        bus.increment = 1'b0;
        show("sat_live", 3'd0, 16'h2047);
        bus.increment = 1'b1;
        bus.is_dead   = 1'b1;
        tick();
        bus.increment = 1'b0;
        bus.is_dead   = 1'b0;
        check("rec_sat", 32'(bus.new_record), 32'd1);
        show("sat_r1", 3'd1, 16'h2047);
        show("sat_r2", 3'd2, 16'h0010);

        // sel change mid-conversion: old conversion completes, then restarts
        show("live_zero", 3'd0, 16'h0000);
        bus.sel = 3'd1;
        tick();
        check("restart_busy_start", 32'(bus.busy), 32'd1);
        repeat (3) tick();
        bus.sel = 3'd2;
        check("restart_hold", 32'(bus.digits), 32'd0);
        for (int i = 0; i < 40 && bus.busy; i++) tick();
        check("restart_first_done", 32'(bus.busy), 32'd0);
        check("restart_first_val", 32'(bus.digits), 32'h2047);
        tick();
        check("restart_busy_again", 32'(bus.busy), 32'd1);
        settle();
        check("restart_second_val", 32'(bus.digits), 32'h0010);

        // Asynchronous reset mid-SHIFT
        bus.sel = 3'd1;
        tick();
        repeat (3) tick();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_digits", 32'(bus.digits), 32'd0);
        tick();
        rst = 1'b1;
        settle();
        check("post_rst_digits", 32'(bus.digits), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
